// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs four bytes (first byte in [31:24]) into one word with a one-cycle strobe.
// Optional macro UART_WORD_TIMEOUT_EN drops a stale partial word after TIMEOUT_BITS idle bit-times.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [31:0] rx,
  output logic        rxValid,
  output logic        frame_err,
  output logic [1:0]  byte_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_cfg_check
    $error("uart_word_rx: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state_r, next_state_s;
  logic            sync1_r, sync2_r, line_d_r;
  logic [CW-1:0]   clk_cnt_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic [23:0]     pack_r;
  logic [1:0]      byte_cnt_r;
  logic [31:0]     rx_r;
  logic            rx_valid_r, frame_err_r;
  logic            start_s, tick_s, accept_s, bad_stop_s;

`ifdef UART_WORD_TIMEOUT_EN
  localparam int GAP_CYCLES = CLKS_PER_BIT * TIMEOUT_BITS;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  logic [GW-1:0] gap_r;
`endif

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      line_d_r <= 1'b1;
    end else begin
      sync1_r  <= uart_rx;
      sync2_r  <= sync1_r;
      line_d_r <= sync2_r;
    end
  end

  // Bit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic and per-cycle sampling events.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    tick_s       = 1'b0;
    accept_s     = 1'b0;
    bad_stop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (line_d_r && !sync2_r) begin
          start_s      = 1'b1;
          next_state_s = START;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (clk_cnt_r == HALF_LAST) begin
          tick_s       = 1'b1;
          next_state_s = sync2_r ? IDLE : DATA;
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        if (clk_cnt_r == FULL_LAST) begin
          tick_s       = 1'b1;
          next_state_s = (bit_cnt_r == 3'd7) ? STOP : DATA;
        end else begin
          next_state_s = DATA;
        end
      end
      STOP: begin
        if (clk_cnt_r == FULL_LAST) begin
          tick_s = 1'b1;
          if (sync2_r) begin
            accept_s     = 1'b1;
            next_state_s = IDLE;
          end else begin
            bad_stop_s   = 1'b1;
            next_state_s = WAIT_IDLE;
          end
        end else begin
          next_state_s = STOP;
        end
      end
      WAIT_IDLE: begin
        if (sync2_r) next_state_s = IDLE;
        else         next_state_s = WAIT_IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Bit timing, byte shifting, word packing and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_r   <= '0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      pack_r      <= 24'h00_0000;
      byte_cnt_r  <= 2'd0;
      rx_r        <= 32'h0000_0000;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_WORD_TIMEOUT_EN
      gap_r       <= '0;
`endif
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (start_s || tick_s || state_r == IDLE || state_r == WAIT_IDLE) clk_cnt_r <= '0;
      else                                                                clk_cnt_r <= clk_cnt_r + CNT_ONE;
      if (start_s)                        bit_cnt_r <= 3'd0;
      else if (tick_s && state_r == DATA) bit_cnt_r <= bit_cnt_r + 3'd1;
      else                                bit_cnt_r <= bit_cnt_r;
      if (tick_s && state_r == DATA) shift_r <= {sync2_r, shift_r[7:1]};
      else                           shift_r <= shift_r;
      if (accept_s) begin
        pack_r <= {pack_r[15:0], shift_r};
        if (byte_cnt_r == 2'd3) begin
          rx_r       <= {pack_r, shift_r};
          rx_valid_r <= 1'b1;
          byte_cnt_r <= 2'd0;
        end else begin
          byte_cnt_r <= byte_cnt_r + 2'd1;
        end
      end else if (bad_stop_s) begin
        frame_err_r <= 1'b1;
        byte_cnt_r  <= 2'd0;
      end else begin
        byte_cnt_r  <= byte_cnt_r;
      end
`ifdef UART_WORD_TIMEOUT_EN
      // Gap counter only runs while a partial word waits in IDLE.
      if (start_s || state_r != IDLE || byte_cnt_r == 2'd0) begin
        gap_r <= '0;
      end else if (gap_r == GAP_LAST) begin
        gap_r      <= '0;
        byte_cnt_r <= 2'd0;
      end else begin
        gap_r <= gap_r + GAP_ONE;
      end
`endif
    end
  end

  assign rx        = rx_r;
  assign rxValid   = rx_valid_r;
  assign frame_err = frame_err_r;
  assign byte_cnt  = byte_cnt_r;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx at CLKS_PER_BIT=16; expectations follow the UART_WORD_TIMEOUT_EN build setting.
module tb_uart_word_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic [31:0] rx;
  logic        rxValid;
  logic        frame_err;
  logic [1:0]  byte_cnt;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int both_cnt  = 0;
  int lat_pos   = 0;

  uart_word_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .rx(rx), .rxValid(rxValid), .frame_err(frame_err), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rxValid)              valid_cnt++;
    if (frame_err)            ferr_cnt++;
    if (rxValid && frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called on a negedge; lat_pos records which stop-bit cycle showed rxValid.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    for (int i = 1; i <= CPB; i++) begin
      @(negedge clk);
      if (rxValid) lat_pos = i;
    end
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8],  1'b1);
    send_byte(w[7:0],   1'b1);
  endtask

  initial begin
    int v0;
    logic [7:0] seq [8];
    seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56; seq[3] = 8'h78;
    seq[4] = 8'hAA; seq[5] = 8'hAA; seq[6] = 8'hAA; seq[7] = 8'hAA;

    uart_rx = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx",        rx,        32'h0000_0000);
    chk("rst_valid",     {31'd0, rxValid},   32'd0);
    chk("rst_ferr",      {31'd0, frame_err}, 32'd0);
    chk("rst_byte_cnt",  {30'd0, byte_cnt},  32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: all-ones word, back-to-back, with latency check on the last byte
    v0 = valid_cnt;
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    lat_pos = 0;
    send_byte(8'hFF, 1'b1);
    chk("ff_pulses",  valid_cnt - v0, 32'd1);
    chk("ff_word",    rx, 32'hFFFF_FFFF);
    chk("ff_latency", lat_pos, 32'd11);

    // 2: two words back-to-back, byte_cnt walks 1,2,3,0
    v0 = valid_cnt;
    for (int i = 0; i < 8; i++) begin
      send_byte(seq[i], 1'b1);
      chk($sformatf("cnt_seq%0d", i), {30'd0, byte_cnt}, (i + 1) % 4);
      if (i == 3) chk("word_12345678", rx, 32'h1234_5678);
    end
    chk("two_pulses", valid_cnt - v0, 32'd2);
    chk("word_aaaa",  rx, 32'hAAAA_AAAA);

    // 3: bad stop bit discards the partial word
    v0 = valid_cnt;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("ferr_pulses",   ferr_cnt, 32'd1);
    chk("ferr_byte_cnt", {30'd0, byte_cnt}, 32'd0);
    chk("ferr_rx_hold",  rx, 32'hAAAA_AAAA);
    chk("ferr_no_valid", valid_cnt - v0, 32'd0);
    send_word(32'h5678_9ABC);
    chk("ferr_next_word", rx, 32'h5678_9ABC);
    chk("ferr_next_pulse", valid_cnt - v0, 32'd1);

    // 4: short low glitch is ignored
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_ferr",     ferr_cnt, 32'd1);
    chk("glitch_byte_cnt", {30'd0, byte_cnt}, 32'd0);
    chk("glitch_rx_hold",  rx, 32'h5678_9ABC);
    send_word(32'hDEAD_BEEF);
    chk("glitch_word", rx, 32'hDEAD_BEEF);

    // 5: reset in the middle of the third byte
    send_byte(8'hC3, 1'b1);
    send_byte(8'h3C, 1'b1);
    uart_rx = 1'b0;
    repeat (CPB + 3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    chk("midrst_rx",       rx, 32'h0000_0000);
    chk("midrst_byte_cnt", {30'd0, byte_cnt}, 32'd0);
    chk("midrst_valid",    {31'd0, rxValid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_ferr",     {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    v0 = valid_cnt;
    send_word(32'h0102_0304);
    chk("postrst_word",  rx, 32'h0102_0304);
    chk("postrst_pulse", valid_cnt - v0, 32'd1);

    // 6: long inter-byte gap
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (600) @(negedge clk);
    chk("gap600_byte_cnt", {30'd0, byte_cnt}, 32'd2);
    repeat (100) @(negedge clk);
`ifdef UART_WORD_TIMEOUT_EN
    chk("gap700_byte_cnt", {30'd0, byte_cnt}, 32'd0);
    chk("gap_rx_hold",     rx, 32'h0102_0304);
    send_word(32'h3344_5566);
    chk("gap_word", rx, 32'h3344_5566);
    chk("gap_end_cnt", {30'd0, byte_cnt}, 32'd0);
`else
    chk("gap700_byte_cnt", {30'd0, byte_cnt}, 32'd2);
    send_word(32'h3344_5566);
    chk("gap_word", rx, 32'h1122_3344);
    chk("gap_end_cnt", {30'd0, byte_cnt}, 32'd2);
`endif

    chk("valid_ferr_overlap", both_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
